// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Scan controller for a bank of up to five seven-segment digits. It holds
// one BCD value per digit and shows the digits one at a time. A blanking
// phase sits between two digits so that the previous pattern cannot ghost
// onto the next digit.
//
// Parameters:
//   DIGITS  number of digits scanned (2..5). Unused SEG_SEL bits stay 0.
//   DIV     clk cycles per scan tick (>= 2). Each SHOW and each BLANK
//           phase lasts DIV cycles.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high; also clears the digit bank
//   wr_en       write strobe for the digit bank
//   wr_addr     digit index to write (0 = least significant); indices
//               >= DIGITS are ignored
//   wr_data     BCD value to store
//   SEG_SEL     one-hot digit enable, registered
//   SEG_DATA    segment pattern (bit0 = a .. bit6 = g, bit7 = dp = 0),
//               registered
//   frame_done  one-cycle pulse, aligned with the outputs leaving the last
//               digit's SHOW phase
//
// Optional feature (compile-time macro SEG_LEADZERO_BLANK_EN):
//   When defined, leading zero digits above digit 0 are blanked.
//   Digit 0 is always shown.
module seg_scan_ctrl #(
    parameter int DIGITS = 5,
    parameter int DIV    = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    output logic [4:0] SEG_SEL,
    output logic [7:0] SEG_DATA,
    output logic       frame_done
);

    localparam int CW = $clog2(DIV);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    // BCD to segment pattern; 10..15 decode to blank.
    function automatic logic [7:0] seg_decode(input logic [3:0] v);
        logic [7:0] p;
        case (v)
            4'd0:    p = 8'b0011_1111;
            4'd1:    p = 8'b0000_0110;
            4'd2:    p = 8'b0101_1011;
            4'd3:    p = 8'b0100_1111;
            4'd4:    p = 8'b0110_0110;
            4'd5:    p = 8'b0110_1101;
            4'd6:    p = 8'b0111_1101;
            4'd7:    p = 8'b0000_0111;
            4'd8:    p = 8'b0111_1111;
            4'd9:    p = 8'b0110_1111;
            default: p = 8'b0000_0000;
        endcase
        return p;
    endfunction

    // ------------------------------------------------------------------
    // Digit bank
    // ------------------------------------------------------------------
    logic [3:0] bank_reg [DIGITS];

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_bank
            // Addresses >= DIGITS never match any entry, so they are ignored.
            always_ff @(posedge clk) begin
                if (rst) begin
                    bank_reg[gi] <= 4'd0;
                end else if (wr_en && (wr_addr == 3'(gi))) begin
                    bank_reg[gi] <= wr_data;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    logic [CW-1:0] count_reg;
    logic          tick;

    assign tick = (count_reg == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Scan FSM: state register
    // ------------------------------------------------------------------
    state_t     state_reg, state_next;
    logic [2:0] idx_reg, idx_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_BLANK;
            // Starting on the last digit makes the first BLANK->SHOW wrap to 0.
            idx_reg   <= 3'(DIGITS - 1);
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    // ------------------------------------------------------------------
    // Scan FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        if (tick) begin
            case (state_reg)
                ST_SHOW: state_next = ST_BLANK;
                default: begin
                    state_next = ST_SHOW;
                    idx_next   = (idx_reg == 3'(DIGITS - 1)) ? 3'd0 : idx_reg + 3'd1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Value of the digit currently selected, plus leading-zero suppression
    // ------------------------------------------------------------------
    logic [3:0] cur_val;
    logic       cur_blank;

    always_comb begin
        cur_val = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_reg == 3'(i)) begin
                cur_val = bank_reg[i];
            end
        end
    end

`ifdef SEG_LEADZERO_BLANK_EN
    // upper_zero[i] is set when digit i and every digit above it hold 0.
    logic [DIGITS:1] upper_zero;

    assign upper_zero[DIGITS] = 1'b1;

    generate
        for (genvar gi = 1; gi < DIGITS; gi++) begin : g_lead_zero
            assign upper_zero[gi] = (bank_reg[gi] == 4'd0) && upper_zero[gi+1];
        end
    endgenerate

    always_comb begin
        cur_blank = 1'b0;
        for (int i = 1; i < DIGITS; i++) begin
            if ((idx_reg == 3'(i)) && upper_zero[i]) begin
                cur_blank = 1'b1;
            end
        end
    end
`else
    assign cur_blank = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Scan FSM: output logic (registered one cycle later)
    // ------------------------------------------------------------------
    logic [4:0] sel_next,  sel_reg;
    logic [7:0] data_next, data_reg;
    logic       fd_next,   fd_stage_reg, frame_done_reg;

    always_comb begin
        sel_next  = 5'd0;
        data_next = 8'd0;
        if (state_reg == ST_SHOW) begin
            sel_next  = 5'd1 << idx_reg;
            data_next = cur_blank ? 8'd0 : seg_decode(cur_val);
        end
        // Marks the tick that ends the last digit's SHOW phase.
        fd_next = tick && (state_reg == ST_SHOW) && (idx_reg == 3'(DIGITS - 1));
    end

    // frame_done goes through two flops so it lines up with SEG_SEL/SEG_DATA,
    // which lag the FSM state by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_reg        <= 5'd0;
            data_reg       <= 8'd0;
            fd_stage_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            sel_reg        <= sel_next;
            data_reg       <= data_next;
            fd_stage_reg   <= fd_next;
            frame_done_reg <= fd_stage_reg;
        end
    end

    assign SEG_SEL    = sel_reg;
    assign SEG_DATA   = data_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl
// Directed bench for seg_scan_ctrl with DIGITS = 5 and DIV = 4.
// The counter n holds the number of rising edges since the last reset edge,
// and outputs are sampled on the falling edge. With this timing the first
// tick lands on edge 4. The registered outputs then show digit 0 from n = 5.
// Phase p of the outputs covers n = 5+4p .. 8+4p, even p = SHOW and odd
// p = BLANK. frame_done is high at n = 41, 81, ...
module tb_seg_scan_ctrl;

    localparam int DIGITS = 5;
    localparam int DIV    = 4;
    localparam int FRAME  = 2 * DIGITS * DIV;

    localparam logic [7:0] P0 = 8'b0011_1111;
    localparam logic [7:0] P1 = 8'b0000_0110;
    localparam logic [7:0] P2 = 8'b0101_1011;
    localparam logic [7:0] P3 = 8'b0100_1111;
    localparam logic [7:0] P4 = 8'b0110_0110;
    localparam logic [7:0] P5 = 8'b0110_1101;
    localparam logic [7:0] P7 = 8'b0000_0111;
    localparam logic [7:0] P8 = 8'b0111_1111;
    localparam logic [7:0] PB = 8'b0000_0000;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic [4:0] SEG_SEL;
    logic [7:0] SEG_DATA;
    logic       frame_done;

    int n;
    int n_checks;
    int n_fail;

    seg_scan_ctrl #(
        .DIGITS(DIGITS),
        .DIV   (DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .SEG_SEL   (SEG_SEL),
        .SEG_DATA  (SEG_DATA),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Digit expected on the outputs after edge k, or -1 when blank.
    function automatic int shown_digit(input int k);
        int m;
        int p;
        if (k <= DIV) return -1;
        m = k - DIV - 1;
        p = m / DIV;
        if ((p % 2) != 0) return -1;
        return (p / 2) % DIGITS;
    endfunction

    function automatic logic [4:0] sel_of(input int d);
        logic [4:0] s;
        s = 5'd0;
        if (d >= 0) s = 5'd1 << d;
        return s;
    endfunction

    function automatic logic fd_at(input int k);
        return (k > 1) && (((k - 1) % FRAME) == 0);
    endfunction

    task automatic cycle();
        @(negedge clk);
        n++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n   = 0;
    endtask

    task automatic write(input logic [2:0] a, input logic [3:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        cycle();
        wr_en   = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        int d;
        logic [7:0] ed;
        @(negedge clk);
        rst   = 1'b1;
        wr_en = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (SEG_SEL !== 5'd0 || SEG_DATA !== 8'd0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in: sel=%b data=%b fd=%b required 00000/00000000/0",
                     SEG_SEL, SEG_DATA, frame_done);
        end
        rst = 1'b0;
        n   = 0;
        n_checks++;
        if (SEG_SEL !== 5'd0 || SEG_DATA !== 8'd0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: sel=%b data=%b fd=%b required 00000/00000000/0",
                     SEG_SEL, SEG_DATA, frame_done);
        end
        while (n < 12) begin
            cycle();
            d  = shown_digit(n);
            ed = (d >= 0) ? P0 : PB;
            n_checks++;
            if (SEG_SEL !== sel_of(d) || SEG_DATA !== ed || frame_done !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_scan n=%0d: sel=%b data=%b fd=%b required %b/%b/0",
                         n, SEG_SEL, SEG_DATA, frame_done, sel_of(d), ed);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_scan();
        logic [7:0] pat [DIGITS];
        int d;
        int pulses;
        logic [7:0] ed;
        pat[0] = P1; pat[1] = P2; pat[2] = P3; pat[3] = P4; pat[4] = P5;
        pulses = 0;
        do_reset();
        for (int i = 0; i < DIGITS; i++) write(3'(i), 4'(i + 1));
        forever begin
            d  = shown_digit(n);
            ed = (d >= 0) ? pat[d] : PB;
            if (frame_done === 1'b1) pulses++;
            n_checks++;
            if (SEG_SEL !== sel_of(d) || SEG_DATA !== ed || frame_done !== fd_at(n)) begin
                n_fail++;
                $display("FAIL scan n=%0d: sel=%b data=%b fd=%b required %b/%b/%b",
                         n, SEG_SEL, SEG_DATA, frame_done, sel_of(d), ed, fd_at(n));
            end
            if (n == 2 * FRAME + DIV + 1) break;
            cycle();
        end
        n_checks++;
        if (pulses != 2) begin
            n_fail++;
            $display("FAIL frame_done_count: got %0d pulses required 2", pulses);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_invalid();
        logic [7:0] pat [DIGITS];
        int d;
        logic [7:0] ed;
        pat[0] = P1; pat[1] = P2; pat[2] = PB; pat[3] = P4; pat[4] = P5;
        do_reset();
        write(3'd0, 4'd1);
        write(3'd1, 4'd2);
        write(3'd2, 4'd12);
        write(3'd3, 4'd4);
        write(3'd4, 4'd5);
        write(3'd6, 4'd8);
        write(3'd5, 4'd8);
        write(3'd7, 4'd8);
        while (n < 8 + FRAME) begin
            d  = shown_digit(n);
            ed = (d >= 0) ? pat[d] : PB;
            n_checks++;
            if (SEG_SEL !== sel_of(d) || SEG_DATA !== ed) begin
                n_fail++;
                $display("FAIL invalid n=%0d: sel=%b data=%b required %b/%b",
                         n, SEG_SEL, SEG_DATA, sel_of(d), ed);
            end
            cycle();
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_live_update();
        do_reset();
        write(3'd0, 4'd3);
        while (n < 6) cycle();
        n_checks++;
        if (SEG_SEL !== 5'b00001 || SEG_DATA !== P3) begin
            n_fail++;
            $display("FAIL live_before: sel=%b data=%b required 00001/%b", SEG_SEL, SEG_DATA, P3);
        end
        write(3'd0, 4'd7);
        n_checks++;
        if (SEG_SEL !== 5'b00001 || SEG_DATA !== P3) begin
            n_fail++;
            $display("FAIL live_write_edge: sel=%b data=%b required 00001/%b", SEG_SEL, SEG_DATA, P3);
        end
        cycle();
        n_checks++;
        if (SEG_SEL !== 5'b00001 || SEG_DATA !== P7) begin
            n_fail++;
            $display("FAIL live_after: sel=%b data=%b required 00001/%b", SEG_SEL, SEG_DATA, P7);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_tick_write();
        do_reset();
        while (n < 11) cycle();
        write(3'd1, 4'd8);
        n_checks++;
        if (SEG_SEL !== 5'd0 || SEG_DATA !== PB) begin
            n_fail++;
            $display("FAIL tick_write_blank: sel=%b data=%b required 00000/%b", SEG_SEL, SEG_DATA, PB);
        end
        cycle();
        n_checks++;
        if (SEG_SEL !== 5'b00010 || SEG_DATA !== P8) begin
            n_fail++;
            $display("FAIL tick_write_show: sel=%b data=%b required 00010/%b", SEG_SEL, SEG_DATA, P8);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_mid_reset();
        int d;
        logic [7:0] ed;
        do_reset();
        for (int i = 0; i < DIGITS; i++) write(3'(i), 4'(i + 1));
        while (n < 30) cycle();
        n_checks++;
        if (SEG_SEL !== 5'b01000 || SEG_DATA !== P4) begin
            n_fail++;
            $display("FAIL mid_reset_pre: sel=%b data=%b required 01000/%b", SEG_SEL, SEG_DATA, P4);
        end
        // Reset with a simultaneous write that must be discarded.
        rst     = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 3'd0;
        wr_data = 4'd9;
        @(negedge clk);
        rst   = 1'b0;
        wr_en = 1'b0;
        n     = 0;
        n_checks++;
        if (SEG_SEL !== 5'd0 || SEG_DATA !== 8'd0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_edge: sel=%b data=%b fd=%b required 00000/00000000/0",
                     SEG_SEL, SEG_DATA, frame_done);
        end
        while (n < 16) begin
            cycle();
            d  = shown_digit(n);
            ed = (d >= 0) ? P0 : PB;
            n_checks++;
            if (SEG_SEL !== sel_of(d) || SEG_DATA !== ed) begin
                n_fail++;
                $display("FAIL mid_reset_restart n=%0d: sel=%b data=%b required %b/%b",
                         n, SEG_SEL, SEG_DATA, sel_of(d), ed);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_leadzero();
        logic [7:0] pat [DIGITS];
        int d;
        logic [7:0] ed;
`ifdef SEG_LEADZERO_BLANK_EN
        pat[0] = P0; pat[1] = P4; pat[2] = PB; pat[3] = PB; pat[4] = PB;
`else
        pat[0] = P0; pat[1] = P4; pat[2] = P0; pat[3] = P0; pat[4] = P0;
`endif
        do_reset();
        write(3'd1, 4'd4);
        while (n < 5 + FRAME) begin
            d  = shown_digit(n);
            ed = (d >= 0) ? pat[d] : PB;
            n_checks++;
            if (SEG_SEL !== sel_of(d) || SEG_DATA !== ed) begin
                n_fail++;
                $display("FAIL leadzero n=%0d: sel=%b data=%b required %b/%b",
                         n, SEG_SEL, SEG_DATA, sel_of(d), ed);
            end
            cycle();
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        rst      = 1'b1;
        wr_en    = 1'b0;
        wr_addr  = 3'd0;
        wr_data  = 4'd0;
        n        = 0;
        n_checks = 0;
        n_fail   = 0;

        test_reset();
        test_scan();
        test_invalid();
        test_live_update();
        test_tick_write();
        test_mid_reset();
        test_leadzero();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
